credit_sequencer: RTL and testbench
===================================

CREDIT_SEQUENCER -- requirements
Module: credit_sequencer

Interface
REQ-001 SHALL have parameter COIN_CYCLES, default 200000, btn_coin pulse length in clocks.
REQ-002 SHALL have parameter GAP_CYCLES, default 200000, low time after each coin pulse.
REQ-003 SHALL have parameter START_CYCLES, default 200000, btn_start pulse length.
REQ-004 SHALL have parameter HOLD_CYCLES, default 400000, lockout after a start pulse.
REQ-005 SHALL have port clk_sys  input  1  system clock; single clock domain, one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port req_start  input  2  player start requests, level, bit0 = 1P, bit1 = 2P.
REQ-008 SHALL have port game_reset  input  1  synchronous abort, active-high.
REQ-009 SHALL have port btn_coin  output  1  coin line to game core.
REQ-010 SHALL have port btn_start  output  2  start lines to game core.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL register req_start and set pending[i] on each 0->1 edge; held levels SHALL NOT retrigger.
REQ-013 SHALL use states IDLE, COIN, GAP, START, HOLD.
REQ-014 In IDLE with any pending bit set, SHALL grant one requester round-robin, clear its pending bit, and enter COIN next cycle.
REQ-015 Round-robin pointer SHALL favour 1P after reset and SHALL flip to the other requester after each completed grant.
REQ-016 Grant to 1P SHALL load coin count 1; grant to 2P SHALL load coin count 2.
REQ-017 COIN SHALL drive btn_coin high for exactly COIN_CYCLES clocks, then enter GAP.
REQ-018 GAP SHALL hold btn_coin low for GAP_CYCLES clocks, then re-enter COIN if coins remain, else START.
REQ-019 START SHALL drive btn_start[granted] high for exactly START_CYCLES clocks, then enter HOLD.
REQ-020 HOLD SHALL last HOLD_CYCLES clocks, then return to IDLE.
REQ-021 Edges arriving while busy SHALL set pending and be served after return to IDLE.
REQ-022 Latency: req edge sampled at cycle n SHALL give btn_coin first high at cycle n+2.
REQ-023 Outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-024 Phase counter SHALL be 20 bits; parameters outside 1..2^20-1 are illegal.
REQ-025 game_reset SHALL, on the next clock, force IDLE, clear pending, reset the pointer to 1P, and drive all outputs low; it overrides any simultaneous edge.

Reset
REQ-026 reset_n low SHALL immediately force IDLE, pending=0, pointer=1P, counters=0, btn_coin=0, btn_start=0, busy=0, including mid-pulse.

Configuration
REQ-027 With CREDIT_SEQ_AUTOSTART_EN defined, SHALL behave per REQ-013..REQ-020.
REQ-028 Without it, START SHALL be skipped (GAP with no coins left -> HOLD), and btn_start SHALL equal req_start delayed one clock.

Structure
REQ-029 Package phoenix_credit_pkg SHALL hold the state enum and the 20-bit counter width constant.
REQ-030 One sub-module, credit_timer (loadable 20-bit down-counter with done flag), SHALL time all phases.

Verification (COIN=4, GAP=3, START=5, HOLD=6, macro defined unless noted)
REQ-031 req_start[0] rises at cycle 0 -> btn_coin high cycles 2-5; btn_start[0] high 9-13; busy low from cycle 20.
REQ-032 req_start[1] rises at cycle 0 -> btn_coin high 2-5 and 9-12; btn_start[1] high 16-20; busy low from 27.
REQ-033 Both bits rise at cycle 0 after reset -> full 1P sequence first, then 2P sequence starting from the IDLE cycle (20) with coin at 21.
REQ-034 game_reset pulsed at cycle 3 during 1P COIN -> btn_coin low at cycle 4, busy low, a later req_start[0] edge is served normally.
REQ-035 req_start[0] held high 100 cycles -> exactly one sequence; reset_n low at cycle 10 -> all outputs 0 immediately.
REQ-036 Macro undefined, req_start[0] rises at cycle 0 -> btn_start[0] high from cycle 1, btn_coin high 2-5, never a generated start pulse.

Source files
------------

// File: rtl/phoenix_credit_pkg.sv
// Shared types for the credit sequencer: FSM state encoding and timer width.
package phoenix_credit_pkg;

   localparam int CNT_W = 20;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_COIN  = 3'd1,
      ST_GAP   = 3'd2,
      ST_START = 3'd3,
      ST_HOLD  = 3'd4
   } state_t;

endpackage

// File: rtl/credit_timer.sv
// Loadable down-counter that times every sequencer phase.
// done is high while the count sits at zero.
module credit_timer
   import phoenix_credit_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] value,
   output logic             done
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= value;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/credit_sequencer.sv
// Coin/start pulse sequencer for 1P/2P start requests (round-robin).
// Build option CREDIT_SEQ_AUTOSTART_EN enables the generated start pulse.
module credit_sequencer
   import phoenix_credit_pkg::*;
#(
   parameter int COIN_CYCLES  = 200000,
   parameter int GAP_CYCLES   = 200000,
   parameter int START_CYCLES = 200000,
   parameter int HOLD_CYCLES  = 400000
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic [1:0] req_start,
   input  logic       game_reset,
   output logic       btn_coin,
   output logic [1:0] btn_start,
   output logic       busy
);

   // Timer holds N-1 on entry so a phase lasts exactly N clocks.
   localparam logic [CNT_W-1:0] COIN_LD  = CNT_W'(COIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
`ifdef CREDIT_SEQ_AUTOSTART_EN
   localparam logic [CNT_W-1:0] START_LD = CNT_W'(START_CYCLES - 1);
`endif

   state_t           state;
   state_t           state_n;
   logic [1:0]       req_q;
   logic [1:0]       pending;
   logic [1:0]       rise;
   logic [1:0]       coins;
   logic             ptr;
   logic             who;
   logic             grant_2p;
   logic             grant;
   logic             t_load;
   logic [CNT_W-1:0] t_value;
   logic             t_done;

   assign rise     = req_start & ~req_q;
   assign grant    = (state == ST_IDLE) && (pending != 2'b00);
   assign grant_2p = pending[1] & (~pending[0] | ptr);

   always_comb begin
      state_n = state;
      t_load  = 1'b0;
      t_value = '0;
      unique case (state)
         ST_IDLE: begin
            if (pending != 2'b00) begin
               state_n = ST_COIN;
               t_load  = 1'b1;
               t_value = COIN_LD;
            end
         end
         ST_COIN: begin
            if (t_done) begin
               state_n = ST_GAP;
               t_load  = 1'b1;
               t_value = GAP_LD;
            end
         end
         ST_GAP: begin
            if (t_done) begin
               t_load = 1'b1;
               if (coins != 2'd0) begin
                  state_n = ST_COIN;
                  t_value = COIN_LD;
               end else begin
`ifdef CREDIT_SEQ_AUTOSTART_EN
                  state_n = ST_START;
                  t_value = START_LD;
`else
                  state_n = ST_HOLD;
                  t_value = HOLD_LD;
`endif
               end
            end
         end
`ifdef CREDIT_SEQ_AUTOSTART_EN
         ST_START: begin
            if (t_done) begin
               state_n = ST_HOLD;
               t_load  = 1'b1;
               t_value = HOLD_LD;
            end
         end
`endif
         ST_HOLD: begin
            if (t_done) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   credit_timer u_timer (
      .clk   (clk_sys),
      .rst_n (reset_n),
      .clr   (game_reset),
      .load  (t_load),
      .value (t_value),
      .done  (t_done)
   );

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         req_q     <= 2'b00;
         pending   <= 2'b00;
         coins     <= 2'd0;
         ptr       <= 1'b0;
         who       <= 1'b0;
         btn_coin  <= 1'b0;
         btn_start <= 2'b00;
         busy      <= 1'b0;
      end else if (game_reset) begin
         state     <= ST_IDLE;
         req_q     <= req_start;
         pending   <= 2'b00;
         coins     <= 2'd0;
         ptr       <= 1'b0;
         who       <= 1'b0;
         btn_coin  <= 1'b0;
         btn_start <= 2'b00;
         busy      <= 1'b0;
      end else begin
         state    <= state_n;
         req_q    <= req_start;
         busy     <= (state_n != ST_IDLE);
         btn_coin <= (state_n == ST_COIN);
`ifdef CREDIT_SEQ_AUTOSTART_EN
         btn_start <= (state_n == ST_START) ? {who, ~who} : 2'b00;
`else
         btn_start <= req_start;
`endif
         if (grant) begin
            pending <= (pending & ~{grant_2p, ~grant_2p}) | rise;
            who     <= grant_2p;
            coins   <= grant_2p ? 2'd2 : 2'd1;
         end else begin
            pending <= pending | rise;
         end
         if (state == ST_COIN && t_done) coins <= coins - 2'd1;
         if (state == ST_HOLD && t_done) ptr <= ~who;
      end
   end

endmodule

// File: tb/tb_credit_sequencer.sv
// Randomised and directed bench for credit_sequencer against a
// timeline model (sequence offsets computed from phase lengths).
module tb_credit_sequencer;

   localparam int C = 4;
   localparam int G = 3;
   localparam int S = 5;
   localparam int H = 6;
`ifdef CREDIT_SEQ_AUTOSTART_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] req = 2'b00;
   logic       grst = 1'b0;
   logic       coin;
   logic [1:0] start;
   logic       busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [1:0] m_prev = 2'b00;
   logic [1:0] m_pend = 2'b00;
   logic       m_ptr = 1'b0;
   logic       m_who = 1'b0;
   logic       m_active = 1'b0;
   int         m_beg = 0;
   int         m_coins = 0;
   logic       e_coin;
   logic [1:0] e_start;
   logic       e_busy;

   always #5 clk = ~clk;

   credit_sequencer #(
      .COIN_CYCLES  (C),
      .GAP_CYCLES   (G),
      .START_CYCLES (S),
      .HOLD_CYCLES  (H)
   ) dut (
      .clk_sys    (clk),
      .reset_n    (rst_n),
      .req_start  (req),
      .game_reset (grst),
      .btn_coin   (coin),
      .btn_start  (start),
      .busy       (busy)
   );

   function automatic int seq_len(int n);
      return n * (C + G) + (AUTO ? S : 0) + H;
   endfunction

   task automatic model_reset();
      m_prev   = 2'b00;
      m_pend   = 2'b00;
      m_ptr    = 1'b0;
      m_active = 1'b0;
   endtask

   // Advance model one clock edge and derive outputs for the new cycle.
   task automatic model_edge();
      logic [1:0] rise;
      int k;
      int cp;
      rise = req & ~m_prev;
      if (grst) begin
         m_pend   = 2'b00;
         m_ptr    = 1'b0;
         m_active = 1'b0;
      end else begin
         if (m_active && cyc == m_beg + seq_len(m_coins)) begin
            m_active = 1'b0;
            m_ptr    = ~m_who;
         end else if (!m_active && m_pend != 2'b00) begin
            m_who         = m_pend[1] && (!m_pend[0] || m_ptr);
            m_pend[m_who] = 1'b0;
            m_coins       = m_who ? 2 : 1;
            m_beg         = cyc;
            m_active      = 1'b1;
         end
         m_pend = m_pend | rise;
      end
      m_prev  = req;
      e_coin  = 1'b0;
      e_start = 2'b00;
      e_busy  = m_active;
      if (m_active) begin
         k  = cyc - m_beg;
         cp = m_coins * (C + G);
         e_coin = (k < cp) && ((k % (C + G)) < C);
         if (AUTO && k >= cp && k < cp + S)
            e_start = m_who ? 2'b10 : 2'b01;
      end
      if (!AUTO) e_start = grst ? 2'b00 : req;
   endtask

   task automatic check(string tag, logic [3:0] got, logic [3:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d got={busy,coin,start}=%b exp=%b",
                tag, cyc, got, exp);
      end
   endtask

   task automatic step(string tag);
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      check(tag, {busy, coin, start}, {e_busy, e_coin, e_start});
   endtask

   task automatic run(string tag, int n);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("async_rst", {busy, coin, start}, 4'b0000);
      model_reset();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      #1 check("reset_state", {busy, coin, start}, 4'b0000);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // 1P: coin appears exactly two edges after the request is sampled
      req = 2'b01;
      step("p1_lat0");
      check("p1_nocoin", {3'b000, coin}, 4'b0000);
      step("p1_lat1");
      check("p1_coin", {3'b000, coin}, 4'b0001);
      run("p1", 25);
      req = 2'b00;
      run("p1_idle", 3);

      req = 2'b10;
      run("p2", 32);
      req = 2'b00;
      run("p2_idle", 3);

      do_reset();
      req = 2'b11;
      run("both", 50);
      req = 2'b00;
      run("both_idle", 3);

      // abort in the middle of the first coin pulse
      do_reset();
      req = 2'b01;
      run("abort_pre", 3);
      grst = 1'b1;
      step("abort");
      grst = 1'b0;
      check("abort_coin", {2'b00, coin, busy}, 4'b0000);
      run("abort_post", 3);
      req = 2'b00;
      step("abort_rel");
      req = 2'b01;
      run("abort_again", 25);

      do_reset();
      req = 2'b01;
      run("held", 100);
      req = 2'b00;
      step("held_rel");
      req = 2'b01;
      run("mid_pulse", 9);
      do_reset();
      req = 2'b00;
      run("after_rst", 3);

      for (int i = 0; i < 900; i++) begin
         if ($urandom_range(0, 99) < 8)
            req[$urandom_range(0, 1)] = ~req[$urandom_range(0, 1)];
         if ($urandom_range(0, 99) < 5)
            req = 2'($urandom_range(0, 3));
         grst = ($urandom_range(0, 249) == 0);
         step("rand");
      end
      grst = 1'b0;
      run("tail", 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
